// File: rtl/xor4x2_pkg.sv
// Shared defaults and helpers for the xor4x2 arbiter slice.
// Optional accumulate feature is selected by macro XOR4X2_ACCUM_EN.
package xor4x2_pkg;

    localparam int XOR4X2_NREQ_DEF  = 2;
    localparam int XOR4X2_WIDTH_DEF = 2;

    // Requester index width; a single requester pair still needs one bit.
    function automatic int xor4x2_id_width(input int nreq);
        if (nreq <= 2) begin
            return 1;
        end else begin
            return $clog2(nreq);
        end
    endfunction

endpackage

// File: rtl/xor4x2_lane.sv
// Shared combinational datapath: WIDTH lanes of 4-input XOR across the
// four operands packed in one word.
module xor4x2_lane
    import xor4x2_pkg::*;
#(
    parameter int WIDTH = XOR4X2_WIDTH_DEF
) (
    input  logic [4*WIDTH-1:0] word,
    output logic [WIDTH-1:0]   res
);

    assign res = word[0*WIDTH +: WIDTH] ^ word[1*WIDTH +: WIDTH]
               ^ word[2*WIDTH +: WIDTH] ^ word[3*WIDTH +: WIDTH];

endmodule

// File: rtl/xor4x2_arbiter.sv
// Round-robin arbiter feeding one shared XOR4 datapath into a single result
// register. Define XOR4X2_ACCUM_EN to enable per-requester group accumulation.
module xor4x2_arbiter
    import xor4x2_pkg::*;
#(
    parameter int NREQ  = XOR4X2_NREQ_DEF,
    parameter int WIDTH = XOR4X2_WIDTH_DEF
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [NREQ-1:0]                    req_valid,
    output logic [NREQ-1:0]                    req_ready,
    input  logic [NREQ*4*WIDTH-1:0]            req_data,
    input  logic [NREQ-1:0]                    req_last,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [WIDTH-1:0]                   res_data,
    output logic [xor4x2_id_width(NREQ)-1:0]   res_id
);

    localparam int IDW = xor4x2_id_width(NREQ);
    localparam int WW  = 4 * WIDTH;

    logic [IDW-1:0]   ptr_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic [IDW-1:0]   res_id_r;

    logic             free_s;
    logic [NREQ-1:0]  elig_s;
    logic [IDW-1:0]   grant_s;
    logic             found_s;
    logic             xfer_s;
    logic             last_s;
    logic [WW-1:0]    word_s;
    logic [WIDTH-1:0] lane_res_s;
    logic [WIDTH-1:0] result_s;

    // A draining result frees the register in the same cycle.
    assign free_s = !res_valid_r || res_ready;

`ifdef XOR4X2_ACCUM_EN
    logic [WIDTH-1:0] acc_r [NREQ];

    // Non-last beats produce no result, so they may proceed while the register is full.
    always_comb begin
        elig_s = req_valid & (free_s ? {NREQ{1'b1}} : ~req_last);
    end

    assign last_s   = req_last[grant_s];
    assign result_s = acc_r[grant_s] ^ lane_res_s;

    // Per-requester accumulators: fold non-last beats, clear on the closing beat.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < NREQ; k++) begin
                acc_r[k] <= {WIDTH{1'b0}};
            end
        end else if (xfer_s) begin
            acc_r[grant_s] <= last_s ? {WIDTH{1'b0}} : (acc_r[grant_s] ^ lane_res_s);
        end
    end
`else
    logic unused_last_s;

    // Every beat produces a result, so nothing is eligible while the register is full.
    always_comb begin
        elig_s = free_s ? req_valid : {NREQ{1'b0}};
    end

    assign unused_last_s = ^req_last;
    assign last_s        = 1'b1;
    assign result_s      = lane_res_s;
`endif

    // Round-robin search over eligible requesters starting at the pointer.
    always_comb begin
        int unsigned idx_v;
        logic        take_v;
        grant_s = {IDW{1'b0}};
        found_s = 1'b0;
        for (int o = 0; o < NREQ; o++) begin
            idx_v   = (int'(ptr_r) + o) % NREQ;
            take_v  = !found_s && elig_s[idx_v];
            grant_s = take_v ? IDW'(idx_v) : grant_s;
            found_s = found_s | take_v;
        end
    end

    assign xfer_s = found_s && !RESET;

    // Ready is one-hot on the granted requester and forced low during reset.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (xfer_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Select the granted word for the shared datapath.
    always_comb begin
        word_s = req_data[int'(grant_s)*WW +: WW];
    end

    xor4x2_lane #(
        .WIDTH (WIDTH)
    ) u_lane (
        .word (word_s),
        .res  (lane_res_s)
    );

    // Pointer moves past the granted requester only on an actual transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_r <= {IDW{1'b0}};
        end else if (xfer_s) begin
            ptr_r <= (int'(grant_s) == NREQ - 1) ? {IDW{1'b0}} : (grant_s + {{(IDW-1){1'b0}}, 1'b1});
        end
    end

    // Result register: load on a producing transfer, drop when drained, hold when stalled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {WIDTH{1'b0}};
            res_id_r    <= {IDW{1'b0}};
        end else if (xfer_s && last_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= result_s;
            res_id_r    <= grant_s;
        end else if (res_ready) begin
            res_valid_r <= 1'b0;
        end
    end

    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;

endmodule

// File: tb/tb_xor4x2_arbiter.sv
// Self-checking bench for xor4x2_arbiter (NREQ=2, WIDTH=2): directed vector
// table, randomized run against a reference model, accumulate sequences when enabled.
module tb_xor4x2_arbiter;

    localparam int N = 2;
    localparam int W = 2;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*4*W-1:0] req_data;
    logic [N-1:0]     req_last;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [0:0]       res_id;

    int checks   = 0;
    int failures = 0;

    // Reference model state: index of the last granted requester.
    int           m_last;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [0:0]   m_id;
    logic [N-1:0] m_ready;

    logic [N-1:0] got_ready;
    logic         got_valid;
    logic [W-1:0] got_data;
    logic [0:0]   got_id;

    typedef struct {
        logic         rst;
        logic [N-1:0] v;
        logic [15:0]  d;
        logic         rr;
        logic [N-1:0] er;
        logic         ev;
        logic [W-1:0] ed;
        logic [0:0]   ei;
    } vec_t;

    vec_t tbl [14];

    xor4x2_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] ref_xor(input logic [4*W-1:0] w);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) r = r ^ w[j*W +: W];
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Drive one cycle, predict with the model, sample ready before and outputs after the edge.
    task automatic apply(input logic rst, input logic [N-1:0] v, input logic [15:0] d, input logic rr);
        int g;
        int k;
        RESET = rst; req_valid = v; req_data = d; res_ready = rr;
        g = -1;
        if (!rst && (!m_valid || rr)) begin
            for (int o = 0; o < N; o++) begin
                k = (m_last + 1 + o) % N;
                if (g < 0 && v[k]) g = k;
            end
        end
        m_ready = (g >= 0) ? N'(1 << g) : '0;
        #1 got_ready = req_ready;
        @(posedge CLK);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_id = '0; m_last = N - 1;
        end else if (g >= 0) begin
            m_valid = 1'b1; m_data = ref_xor(d[g*4*W +: 4*W]); m_id = 1'(g); m_last = g;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        #1;
        got_valid = res_valid; got_data = res_data; got_id = res_id;
    endtask

`ifdef XOR4X2_ACCUM_EN
    // Single accepted beat from requester k with operand0 = lane value.
    task automatic acc_beat(input string name, input int k, input logic [W-1:0] lane, input logic last,
                            input logic ev, input logic [W-1:0] ed, input logic [0:0] ei);
        RESET = 1'b0; res_ready = 1'b1;
        req_valid = N'(1 << k);
        req_data  = '0;
        req_data[k*4*W +: W] = lane;
        req_last  = N'(last) << k;
        #1 chk({name, "_ready"}, 8'(req_ready), 8'(N'(1 << k)));
        @(posedge CLK); #1;
        chk({name, "_valid"}, 8'(res_valid), 8'(ev));
        if (ev) begin
            chk({name, "_data"}, 8'(res_data), 8'(ed));
            chk({name, "_id"}, 8'(res_id), 8'(ei));
        end
    endtask
`endif

    initial begin
        // rst, valid, data{req1,req0}, res_ready, exp ready, exp valid, exp data, exp id
        tbl[0]  = '{1'b1, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 2'b11, 16'h0301, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0};
        tbl[2]  = '{1'b0, 2'b11, 16'h0301, 1'b1, 2'b10, 1'b1, 2'b11, 1'b1};
        tbl[3]  = '{1'b0, 2'b11, 16'h0301, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0};
        tbl[4]  = '{1'b0, 2'b11, 16'h0301, 1'b1, 2'b10, 1'b1, 2'b11, 1'b1};
        tbl[5]  = '{1'b0, 2'b01, 16'h00E4, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0};
        tbl[6]  = '{1'b0, 2'b11, 16'h0301, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0};
        tbl[7]  = '{1'b0, 2'b11, 16'h0301, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0};
        tbl[8]  = '{1'b0, 2'b11, 16'h0301, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0};
        tbl[9]  = '{1'b0, 2'b11, 16'h0301, 1'b1, 2'b10, 1'b1, 2'b11, 1'b1};
        tbl[10] = '{1'b0, 2'b11, 16'h0301, 1'b0, 2'b00, 1'b1, 2'b11, 1'b1};
        tbl[11] = '{1'b1, 2'b11, 16'h0301, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        tbl[12] = '{1'b0, 2'b11, 16'h0301, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 16'h0000, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0};

        RESET = 1'b1; req_valid = '0; req_data = '0; req_last = '1; res_ready = 1'b0;
        m_last = N - 1; m_valid = 1'b0; m_data = '0; m_id = '0;

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].rr);
            chk($sformatf("vec%0d_ready", i), 8'(got_ready), 8'(tbl[i].er));
            chk($sformatf("vec%0d_valid", i), 8'(got_valid), 8'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i),  8'(got_data),  8'(tbl[i].ed));
            chk($sformatf("vec%0d_id", i),    8'(got_id),    8'(tbl[i].ei));
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 39) == 0), N'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) != 0));
            chk($sformatf("rnd%0d_ready", i), 8'(got_ready), 8'(m_ready));
            chk($sformatf("rnd%0d_valid", i), 8'(got_valid), 8'(m_valid));
            chk($sformatf("rnd%0d_data", i),  8'(got_data),  8'(m_data));
            chk($sformatf("rnd%0d_id", i),    8'(got_id),    8'(m_id));
        end

`ifdef XOR4X2_ACCUM_EN
        acc_beat("acc1_b0", 1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        acc_beat("acc1_b1", 1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        acc_beat("acc1_b2", 1, 2'b10, 1'b1, 1'b1, 2'b00, 1'b1);
        acc_beat("il_r0a",  0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        acc_beat("il_r1a",  1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
        acc_beat("il_r0b",  0, 2'b10, 1'b1, 1'b1, 2'b11, 1'b0);
        acc_beat("il_r1b",  1, 2'b01, 1'b1, 1'b1, 2'b10, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor4x2_arbiter.md
XOR4X2_ARBITER -- requirements
Module: xor4x2_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter WIDTH, default 2, bits per XOR lane; operand word is 4*WIDTH bits.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-007 SHALL have port req_data  input  NREQ*4*WIDTH  operand words; requester k occupies slice k; within a word, operand j (j=0..3) occupies bits [j*WIDTH +: WIDTH].
REQ-008 SHALL have port req_last  input  NREQ  end-of-group flag; used only under XOR4X2_ACCUM_EN.
REQ-009 SHALL have port res_valid  output  1  result register holds a result.
REQ-010 SHALL have port res_ready  input  1  downstream accept.
REQ-011 SHALL have port res_data  output  WIDTH  lane-wise XOR result.
REQ-012 SHALL have port res_id  output  clog2(NREQ), minimum 1  index of the requester that produced res_data.

Function
REQ-013 SHALL share one XOR datapath: res bit i = op0[i]^op1[i]^op2[i]^op3[i] for the granted word.
REQ-014 SHALL grant at most one requester per cycle, round-robin; search starts at the index after the last granted requester.
REQ-015 SHALL assert req_ready only for the granted requester, only when its req_valid is high and the result register is free.
REQ-016 SHALL consider the result register free when res_valid=0, or when res_valid=1 and res_ready=1 in the same cycle (drain and refill, no bubble).
REQ-017 SHALL load res_data/res_id on the cycle after the transfer, giving 1-cycle latency, and hold them stable while res_valid=1 and res_ready=0.
REQ-018 SHALL update the round-robin pointer only on an actual transfer; an idle or stalled cycle leaves it unchanged.
REQ-019 SHALL sustain 1 result per cycle when res_ready is held high.
REQ-020 SHALL let a requester that drops req_valid before acceptance lose its turn without pointer movement.
REQ-021 SHALL wrap the pointer from NREQ-1 to 0.

Reset
REQ-022 SHALL on RESET=1 clear res_valid, res_data, res_id and req_ready to 0, set the pointer so requester 0 has top priority, and clear all accumulators.
REQ-023 SHALL let reset override an in-flight transfer or stalled result; the result is discarded.
REQ-024 SHALL hold req_ready at 0 during reset.

Configuration
REQ-025 SHALL compile in the accumulate feature only when macro XOR4X2_ACCUM_EN is defined.
REQ-026 SHALL with XOR4X2_ACCUM_EN keep one WIDTH-bit accumulator per requester; each accepted beat XORs its lane result into it, and only a beat with req_last=1 produces a result equal to accumulator^beat, which then clears that accumulator.
REQ-027 SHALL with XOR4X2_ACCUM_EN grant a non-last beat even when the result register is full, since it produces no result; it still advances the pointer.
REQ-028 SHALL without XOR4X2_ACCUM_EN treat every beat as last, ignore req_last, and instantiate no accumulators.

Structure
REQ-029 SHALL place the WIDTH default, NREQ default, and id-width function in package xor4x2_pkg.
REQ-030 SHALL instantiate the shared XOR datapath as sub-module xor4x2_lane (combinational, WIDTH lanes of 4-input XOR).

Verification
REQ-031 SHALL cover single request: req0 data 8'b11_10_01_00, res_ready=1 -> next cycle res_valid=1, res_data=2'b00, res_id=0.
REQ-032 SHALL cover contention: req0 and req1 both valid continuously for 4 beats -> res_id sequence 0,1,0,1 with no idle cycles.
REQ-033 SHALL cover backpressure: res_ready=0 for 3 cycles with a result held -> res_data/res_id stable and req_ready=0; on release, the next result follows with no bubble.
REQ-034 SHALL cover reset mid-stall: RESET pulsed while res_valid=1 -> res_valid=0 next cycle and the first post-reset grant goes to requester 0.
REQ-035 SHALL cover accumulate (XOR4X2_ACCUM_EN): req1 beats with lane results 2'b01, 2'b11, 2'b10(last) -> single result 2'b00, res_id=1.
REQ-036 SHALL cover accumulate interleaving: req0 and req1 groups interleaved -> each result equals the XOR of only its own requester's beats.
